wt_store_wbuf: RTL and testbench
================================

// Module: wt_store_wbuf
// PURPOSE
// - Write buffer between the store unit and the write-through dcache memory port of the cv32a6 FPGA core.
// - Absorbs up to DEPTH outstanding word stores.
// - Merges byte-enables of stores to the same word that has not yet been issued.
// - Issues stores to memory with a transaction id and frees each entry on the matching ack.
// - Flags loads that hit a buffered word, so the load unit stalls them.
// PARAMETERS
// - XLEN     32  data width; BE_W = XLEN/8.
// - DEPTH    2   number of entries (WtDcacheWbufDepth).
// - PADDR_W  34  physical address width (Sv32).
// - TID_W    2   memory transaction id width (MemTidWidth); DEPTH <= 2**TID_W is required.
// PORTS
// - clk_i          in   1        clock
// - rst_ni         in   1        asynchronous reset, active low
// - st_valid_i     in   1        store request
// - st_ready_o     out  1        store accepted when valid&ready
// - st_paddr_i     in   PADDR_W  store byte address; word = paddr[PADDR_W-1:2]
// - st_data_i      in   XLEN     store data, lane-aligned
// - st_be_i        in   BE_W     byte enables
// - mem_req_o      out  1        memory write request
// - mem_gnt_i      in   1        request granted this cycle
// - mem_paddr_o    out  PADDR_W  word-aligned address (low 2 bits = 0)
// - mem_data_o     out  XLEN     write data
// - mem_be_o       out  BE_W     byte enables
// - mem_tid_o      out  TID_W    transaction id = entry index
// - mem_ack_i      in   1        write completion
// - mem_ack_tid_i  in   TID_W    id of the completed write
// - ld_paddr_i     in   PADDR_W  load address to check
// - ld_hit_o       out  1        word match against any non-FREE entry
// - empty_o        out  1        all entries FREE
// BEHAVIOUR
// - Per-entry state machine: FREE -> PEND on allocate; PEND -> INFL on gnt; INFL -> FREE on ack with tid = index.
// - Reset: all entries FREE. mem_req_o=0, ld_hit_o=0, empty_o=1, st_ready_o=1.
// - Merge: the store word equals a PEND entry's word and that entry is not the one driven on mem_req_o this cycle.
//   - For each set be bit, the byte is overwritten with the new data.
//   - The entry's be becomes old|new. No allocation.
// - Allocate: no merge is possible. The store goes into the lowest-index FREE entry.
// - Stores never merge into an INFL entry.
// - st_ready_o = merge possible | any FREE entry. Computed from registered state only; a same-cycle ack does not raise ready.
// - Issue eligibility: a PEND entry whose word matches an INFL entry is not eligible until that INFL entry is acked.
//   - This keeps same-address stores in order.
// - Issue selection: lowest-index eligible PEND entry. The selection is registered.
//   - A store accepted in cycle N can appear on mem_req_o at the earliest in cycle N+1.
// - Request hold: while mem_req_o=1 and mem_gnt_i=0, the address, data, be and tid stay stable and the selection does not change.
// - Grant: in the gnt cycle the entry becomes INFL. The next eligible entry may be requested in the following cycle.
// - Ack: frees the entry the next cycle.
//   - An ack whose tid is not INFL is ignored; an assertion fires.
//   - Ack and allocate in the same cycle on different entries are both handled.
// - ld_hit_o: combinational compare of ld_paddr_i[PADDR_W-1:2] against every PEND or INFL entry.
// - empty_o: registered-derived; 1 only when no entry is PEND or INFL.
// - Reset mid-operation drops all entries. Outstanding acks that arrive after reset are ignored.
// STRUCTURE
// - Shared package wt_wbuf_pkg:
//   - typedef enum logic [1:0] wbuf_state_e {FREE, PEND, INFL}
//   - typedef struct wbuf_entry_t {state, word addr, data, be}
// - Sub-module: lzc from common_cells, used twice:
//   - free-entry select
//   - eligible-PEND select
// - Assertions:
//   - DEPTH <= 2**TID_W
//   - request stable until gnt
//   - no ack for a non-INFL tid
// TESTING
// - Single store: 0x8000_0010, data 0xDEADBEEF, be 0xF.
//   -> mem_req_o next cycle, tid 0. After gnt and ack tid 0 -> empty_o=1 one cycle later.
// - Merge: store 0x8000_0010 be 0x3 data 0x0000_1111, then the same word be 0xC data 0x2222_0000, both before gnt.
//   -> a single request with data 0x2222_1111, be 0xF.
// - Full: two stores to distinct words, gnt held low.
//   -> a third store to a new word sees st_ready_o=0 until an ack; it is then accepted into the freed entry.
// - Ordering: entry 0 INFL at 0x8000_0020, then a store to the same word.
//   -> allocates entry 1; mem_req_o stays 0 until ack tid 0, then requests tid 1.
// - Load hit: PEND word 0x8000_0040 with ld_paddr_i=0x8000_0042 -> ld_hit_o=1. After its ack -> ld_hit_o=0.
// - Reset: rst_ni low with one INFL and one PEND entry.
//   -> mem_req_o=0, empty_o=1, st_ready_o=1. A later ack tid 0 is ignored.

Source files
------------

// File: rtl/wt_wbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wt_wbuf_pkg                                                  |
// | Description : Shared types and helpers for the write-through store buffer. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package wt_wbuf_pkg;

  localparam int unsigned WBUF_XLEN    = 32;
  localparam int unsigned WBUF_PADDR_W = 34;
  localparam int unsigned WBUF_BE_W    = WBUF_XLEN / 8;
  localparam int unsigned WBUF_WADDR_W = WBUF_PADDR_W - 2;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    INFL = 2'd2
  } wbuf_state_e;

  typedef struct packed {
    wbuf_state_e               state;
    logic [WBUF_WADDR_W-1:0]   waddr;
    logic [WBUF_XLEN-1:0]      data;
    logic [WBUF_BE_W-1:0]      be;
  } wbuf_entry_t;

  // Byte-lane overwrite of buffered data with the enabled lanes of a new store.
  function automatic logic [WBUF_XLEN-1:0] wbuf_merge(
    input logic [WBUF_XLEN-1:0] old_data,
    input logic [WBUF_XLEN-1:0] new_data,
    input logic [WBUF_BE_W-1:0] be
  );
    logic [WBUF_XLEN-1:0] res;
    res = old_data;
    for (int b = 0; b < int'(WBUF_BE_W); b++) begin
      if (be[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wt_store_wbuf_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wt_store_wbuf_lzc                                            |
// | Description : Index of the lowest set bit, with an all-zero flag.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module wt_store_wbuf_lzc #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_i[i]) cnt_o = CNT_W'(i);
    end
  end

  assign empty_o = ~|in_i;

endmodule
`default_nettype wire

// File: rtl/wt_store_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wt_store_wbuf                                                |
// | Description : Merging write buffer between store unit and memory port.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module wt_store_wbuf
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned XLEN    = WBUF_XLEN,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PADDR_W = WBUF_PADDR_W,
  parameter int unsigned TID_W   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 st_valid_i,
  output logic                 st_ready_o,
  input  logic [PADDR_W-1:0]   st_paddr_i,
  input  logic [XLEN-1:0]      st_data_i,
  input  logic [XLEN/8-1:0]    st_be_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [PADDR_W-1:0]   mem_paddr_o,
  output logic [XLEN-1:0]      mem_data_o,
  output logic [XLEN/8-1:0]    mem_be_o,
  output logic [TID_W-1:0]     mem_tid_o,
  input  logic                 mem_ack_i,
  input  logic [TID_W-1:0]     mem_ack_tid_i,
  input  logic [PADDR_W-1:0]   ld_paddr_i,
  output logic                 ld_hit_o,
  output logic                 empty_o
);

  localparam int unsigned WADDR_W = PADDR_W - 2;

  if (DEPTH > (1 << TID_W)) begin : g_bad_depth
    $error("wt_store_wbuf: DEPTH exceeds the transaction id space");
  end
  if ((XLEN != WBUF_XLEN) || (PADDR_W != WBUF_PADDR_W)) begin : g_bad_width
    $error("wt_store_wbuf: widths must match wt_wbuf_pkg");
  end

  wbuf_entry_t        entry_q [DEPTH];
  wbuf_entry_t        entry_d [DEPTH];
  logic               req_valid_q, req_valid_d;
  logic [TID_W-1:0]   req_idx_q, req_idx_d;

  logic [WADDR_W-1:0] w_st_waddr, w_ld_waddr;
  logic [DEPTH-1:0]   w_free, w_merge, w_hit, w_busy, w_elig;
  logic               w_merge_any, w_free_none, w_elig_none, w_st_fire;
  logic [TID_W-1:0]   w_merge_idx, w_free_idx, w_elig_idx;
  logic               w_unused;

  assign w_st_waddr = st_paddr_i[PADDR_W-1:2];
  assign w_ld_waddr = ld_paddr_i[PADDR_W-1:2];
  assign w_unused   = ^{st_paddr_i[1:0], ld_paddr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '{state: FREE, waddr: '0, data: '0, be: '0};
      end
      req_valid_q <= 1'b0;
      req_idx_q   <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
      req_valid_q <= req_valid_d;
      req_idx_q   <= req_idx_d;
    end
  end

  // Descending scan so the lowest matching index wins the merge.
  always_comb begin
    w_free      = '0;
    w_busy      = '0;
    w_hit       = '0;
    w_merge     = '0;
    w_merge_any = 1'b0;
    w_merge_idx = '0;
    mem_paddr_o = '0;
    mem_data_o  = '0;
    mem_be_o    = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_free[i]  = (entry_q[i].state == FREE);
      w_busy[i]  = (entry_q[i].state == PEND) || (entry_q[i].state == INFL);
      w_hit[i]   = w_busy[i] && (entry_q[i].waddr == w_ld_waddr);
      w_merge[i] = (entry_q[i].state == PEND) && (entry_q[i].waddr == w_st_waddr) &&
                   !(req_valid_q && (req_idx_q == TID_W'(i)));
      if (w_merge[i]) begin
        w_merge_any = 1'b1;
        w_merge_idx = TID_W'(i);
      end
      if (req_idx_q == TID_W'(i)) begin
        mem_paddr_o = {entry_q[i].waddr, 2'b00};
        mem_data_o  = entry_q[i].data;
        mem_be_o    = entry_q[i].be;
      end
    end
  end

  assign st_ready_o = w_merge_any | ~w_free_none;
  assign w_st_fire  = st_valid_i & st_ready_o;
  assign mem_req_o  = req_valid_q;
  assign mem_tid_o  = req_idx_q;
  assign ld_hit_o   = |w_hit;
  assign empty_o    = ~|w_busy;

  wt_store_wbuf_lzc #(.WIDTH(DEPTH), .CNT_W(TID_W)) u_free_sel (
    .in_i    (w_free),
    .cnt_o   (w_free_idx),
    .empty_o (w_free_none)
  );

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      entry_d[i] = entry_q[i];
      if (req_valid_q && mem_gnt_i && (req_idx_q == TID_W'(i))) entry_d[i].state = INFL;
      if (mem_ack_i && (mem_ack_tid_i == TID_W'(i)) && (entry_q[i].state == INFL)) begin
        entry_d[i].state = FREE;
      end
      if (w_st_fire) begin
        if (w_merge_any && (w_merge_idx == TID_W'(i))) begin
          entry_d[i].data = wbuf_merge(entry_q[i].data, st_data_i, st_be_i);
          entry_d[i].be   = entry_q[i].be | st_be_i;
        end else if (!w_merge_any && (w_free_idx == TID_W'(i))) begin
          entry_d[i] = '{state: PEND, waddr: w_st_waddr, data: st_data_i, be: st_be_i};
        end
      end
    end
  end

  // Eligibility looks at next state so a fresh store can be requested next cycle.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_elig[i] = (entry_d[i].state == PEND);
      for (int j = 0; j < int'(DEPTH); j++) begin
        if ((entry_d[j].state == INFL) && (entry_d[j].waddr == entry_d[i].waddr)) w_elig[i] = 1'b0;
      end
    end
  end

  wt_store_wbuf_lzc #(.WIDTH(DEPTH), .CNT_W(TID_W)) u_elig_sel (
    .in_i    (w_elig),
    .cnt_o   (w_elig_idx),
    .empty_o (w_elig_none)
  );

  always_comb begin
    req_valid_d = req_valid_q;
    req_idx_d   = req_idx_q;
    if (!req_valid_q || mem_gnt_i) begin
      req_valid_d = ~w_elig_none;
      req_idx_d   = w_elig_idx;
    end
  end

`ifndef SYNTHESIS
  // Ids are presumed possibly in flight after reset until their first ack.
  logic [DEPTH-1:0] stale_q;
  logic             w_ack_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stale_q <= '1;
    end else if (mem_ack_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (mem_ack_tid_i == TID_W'(i)) stale_q[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_ack_ok = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((mem_ack_tid_i == TID_W'(i)) && ((entry_q[i].state == INFL) || stale_q[i])) w_ack_ok = 1'b1;
    end
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_tid_o) && $stable(mem_paddr_o) &&
                                   $stable(mem_data_o) && $stable(mem_be_o)))
    else $error("wt_store_wbuf: request changed before grant");

  a_ack_infl: assert property (@(posedge clk_i) disable iff (!rst_ni) mem_ack_i |-> w_ack_ok)
    else $error("wt_store_wbuf: ack for an id that is not in flight");
`endif

endmodule
`default_nettype wire

// File: tb/tb_wt_store_wbuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wt_store_wbuf                                             |
// | Description : Scoreboard bench for the merging store write buffer.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_wt_store_wbuf;

  localparam int XLEN    = 32;
  localparam int PADDR_W = 34;
  localparam int BE_W    = 4;
  localparam int TID_W   = 2;

  typedef struct {
    logic [PADDR_W-1:0] paddr;
    logic [XLEN-1:0]    data;
    logic [BE_W-1:0]    be;
    logic [TID_W-1:0]   tid;
  } req_t;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               st_valid_i = 1'b0;
  logic               st_ready_o;
  logic [PADDR_W-1:0] st_paddr_i = '0;
  logic [XLEN-1:0]    st_data_i = '0;
  logic [BE_W-1:0]    st_be_i = '0;
  logic               mem_req_o;
  logic               mem_gnt_i = 1'b0;
  logic [PADDR_W-1:0] mem_paddr_o;
  logic [XLEN-1:0]    mem_data_o;
  logic [BE_W-1:0]    mem_be_o;
  logic [TID_W-1:0]   mem_tid_o;
  logic               mem_ack_i = 1'b0;
  logic [TID_W-1:0]   mem_ack_tid_i = '0;
  logic [PADDR_W-1:0] ld_paddr_i = 34'h0_8000_0010;
  logic               ld_hit_o;
  logic               empty_o;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_i = ~clk_i;

  wt_store_wbuf dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .st_valid_i    (st_valid_i),
    .st_ready_o    (st_ready_o),
    .st_paddr_i    (st_paddr_i),
    .st_data_i     (st_data_i),
    .st_be_i       (st_be_i),
    .mem_req_o     (mem_req_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_paddr_o   (mem_paddr_o),
    .mem_data_o    (mem_data_o),
    .mem_be_o      (mem_be_o),
    .mem_tid_o     (mem_tid_o),
    .mem_ack_i     (mem_ack_i),
    .mem_ack_tid_i (mem_ack_tid_i),
    .ld_paddr_i    (ld_paddr_i),
    .ld_hit_o      (ld_hit_o),
    .empty_o       (empty_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [PADDR_W-1:0] a, input logic [XLEN-1:0] d,
                      input logic [BE_W-1:0] b, input logic [TID_W-1:0] t);
    req_t r;
    r.paddr = a; r.data = d; r.be = b; r.tid = t;
    exp_q.push_back(r);
  endtask

  task automatic store(input logic [PADDR_W-1:0] a, input logic [XLEN-1:0] d, input logic [BE_W-1:0] b);
    int n = 0;
    st_valid_i = 1'b1; st_paddr_i = a; st_data_i = d; st_be_i = b;
    #1;
    while (!st_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL store_ready_timeout: addr %0h never accepted, expected ready within 20 cycles", a);
    end
    tick();
    st_valid_i = 1'b0;
  endtask

  task automatic grant(input int n);
    mem_gnt_i = 1'b1;
    repeat (n) tick();
    mem_gnt_i = 1'b0;
  endtask

  task automatic ack(input logic [TID_W-1:0] t);
    mem_ack_i = 1'b1; mem_ack_tid_i = t;
    tick();
    mem_ack_i = 1'b0;
  endtask

  // Monitor: every granted request is popped from the scoreboard and compared.
  initial begin : monitor
    req_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && mem_req_o && mem_gnt_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mem_req_unexpected: got paddr %0h tid %0d, expected no request", mem_paddr_o, mem_tid_o);
        end else begin
          e = exp_q.pop_front();
          if (mem_paddr_o !== e.paddr || mem_data_o !== e.data || mem_be_o !== e.be || mem_tid_o !== e.tid) begin
            errors++;
            $display("FAIL mem_req: got paddr %0h data %0h be %0h tid %0d, expected paddr %0h data %0h be %0h tid %0d",
                     mem_paddr_o, mem_data_o, mem_be_o, mem_tid_o, e.paddr, e.data, e.be, e.tid);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    chk("reset_req", mem_req_o, 0);
    chk("reset_empty", empty_o, 1);
    chk("reset_ready", st_ready_o, 1);
    chk("reset_ld_hit", ld_hit_o, 0);

    // Single store
    push(34'h0_8000_0010, 32'hDEADBEEF, 4'hF, 0);
    store(34'h0_8000_0010, 32'hDEADBEEF, 4'hF);
    chk("single_req_next_cycle", mem_req_o, 1);
    chk("single_not_empty", empty_o, 0);
    grant(1);
    chk("single_req_dropped", mem_req_o, 0);
    chk("single_empty_infl", empty_o, 0);
    ack(0);
    chk("single_empty_after_ack", empty_o, 1);

    // Merge behind a held request to another word
    push(34'h0_8000_0030, 32'hAAAA5555, 4'hF, 0);
    push(34'h0_8000_0010, 32'h22221111, 4'hF, 1);
    store(34'h0_8000_0030, 32'hAAAA5555, 4'hF);
    store(34'h0_8000_0010, 32'h00001111, 4'h3);
    store(34'h0_8000_0010, 32'h22220000, 4'hC);
    chk("merge_hold_req", mem_req_o, 1);
    chk("merge_hold_tid", mem_tid_o, 0);
    st_paddr_i = 34'h0_8000_0070;
    #1;
    chk("merge_full_new_word_ready", st_ready_o, 0);
    grant(2);
    chk("merge_idle", mem_req_o, 0);
    ack(0);
    ack(1);
    chk("merge_empty", empty_o, 1);

    // Full buffer, third store waits for an ack
    push(34'h0_8000_0050, 32'h55555555, 4'hF, 0);
    push(34'h0_8000_0060, 32'h66666666, 4'hF, 1);
    store(34'h0_8000_0050, 32'h55555555, 4'hF);
    store(34'h0_8000_0060, 32'h66666666, 4'hF);
    st_valid_i = 1'b1; st_paddr_i = 34'h0_8000_0070; st_data_i = 32'h77777777; st_be_i = 4'hF;
    #1;
    chk("full_ready_low", st_ready_o, 0);
    grant(1);
    chk("full_ready_low_infl", st_ready_o, 0);
    chk("full_next_tid", mem_tid_o, 1);
    tick();
    mem_ack_i = 1'b1; mem_ack_tid_i = 0;
    #1;
    chk("full_ready_same_cycle_ack", st_ready_o, 0);
    tick();
    mem_ack_i = 1'b0;
    chk("full_ready_after_ack", st_ready_o, 1);
    push(34'h0_8000_0070, 32'h77777777, 4'hF, 0);
    tick();
    st_valid_i = 1'b0;
    chk("full_held_tid", mem_tid_o, 1);
    grant(2);
    ack(1);
    ack(0);
    chk("full_empty", empty_o, 1);

    // Same-word ordering behind an in-flight entry
    push(34'h0_8000_0020, 32'h11111111, 4'hF, 0);
    push(34'h0_8000_0020, 32'h22222222, 4'hF, 1);
    store(34'h0_8000_0020, 32'h11111111, 4'hF);
    grant(1);
    store(34'h0_8000_0020, 32'h22222222, 4'hF);
    chk("order_blocked_0", mem_req_o, 0);
    tick();
    chk("order_blocked_1", mem_req_o, 0);
    ack(0);
    chk("order_req_after_ack", mem_req_o, 1);
    chk("order_tid_after_ack", mem_tid_o, 1);
    grant(1);
    ack(1);
    chk("order_empty", empty_o, 1);

    // Load hit
    ld_paddr_i = 34'h0_8000_0042;
    push(34'h0_8000_0040, 32'h12345678, 4'hF, 0);
    store(34'h0_8000_0040, 32'h12345678, 4'hF);
    chk("ld_hit_pend", ld_hit_o, 1);
    ld_paddr_i = 34'h0_8000_0044;
    #1;
    chk("ld_miss_other_word", ld_hit_o, 0);
    ld_paddr_i = 34'h0_8000_0042;
    #1;
    grant(1);
    chk("ld_hit_infl", ld_hit_o, 1);
    ack(0);
    chk("ld_hit_after_ack", ld_hit_o, 0);

    // Reset with one INFL and one PEND entry
    push(34'h0_8000_0080, 32'h80808080, 4'hF, 0);
    store(34'h0_8000_0080, 32'h80808080, 4'hF);
    grant(1);
    store(34'h0_8000_0090, 32'h90909090, 4'hF);
    chk("pre_reset_req", mem_req_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", st_ready_o, 1);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    ack(0);
    chk("stale_ack_empty", empty_o, 1);
    chk("stale_ack_req", mem_req_o, 0);
    push(34'h0_8000_00A0, 32'hABCD0123, 4'hF, 0);
    store(34'h0_8000_00A0, 32'hABCD0123, 4'hF);
    chk("post_reset_req", mem_req_o, 1);
    chk("post_reset_tid", mem_tid_o, 0);
    grant(1);
    ack(0);
    chk("post_reset_empty", empty_o, 1);

    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
